mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_ctrl_if.sv | 47 ++++
 rtl/mem_ext.sv | 34 +++
 rtl/mem_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_ctrl.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared defines for the memory controller: stall levels,
// FSM state encoding, access-size codes and widths.
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    STALL_NONE = 2'd0,
    STALL_IF   = 2'd1,
    STALL_ALL  = 2'd2
  } stall_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  // Unused size code 3 falls through to a full word.
  function automatic logic [CNT_W-1:0] len_bytes(
    input logic [1:0] len
  );
    logic [CNT_W-1:0] n;
    unique case (len)
      LEN_B:   n = 3'd1;
      LEN_H:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the core, the memory controller
// and the byte-wide RAM.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [DATA_W-1:0] if_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic              mem_sext;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall_req;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_addr,
    output mem_len, mem_sext, mem_wdata,
    output ram_din,
    input  if_done, if_data,
    input  mem_done, mem_rdata, mem_stall_req,
    input  ram_addr, ram_wr, ram_dout
  );

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_addr,
    input  mem_len, mem_sext, mem_wdata,
    input  ram_din,
    output if_done, if_data,
    output mem_done, mem_rdata, mem_stall_req,
    output ram_addr, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ext.sv
// Merges the incoming RAM byte into the read buffer and
// sign/zero-extends the assembled load value.
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [7:0]        din,
  input  logic [1:0]        idx,
  input  logic [CNT_W-1:0]  n_bytes,
  input  logic              sext,
  output logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    word = raw;
    unique case (idx)
      2'd0: word[7:0]   = din;
      2'd1: word[15:8]  = din;
      2'd2: word[23:16] = din;
      2'd3: word[31:24] = din;
    endcase
  end

  always_comb begin
    ext = word;
    unique case (n_bytes)
      3'd1: ext = {{24{sext & word[7]}}, word[7:0]};
      3'd2: ext = {{16{sext & word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle byte-serial memory controller shared by
// instruction fetch and data load/store.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, n_bytes;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata, rbuf;
  logic [DATA_W-1:0] if_data_q, mem_rdata_q;
  logic [DATA_W-1:0] asm_word, ext_word;
  logic              sext, fetch;
  logic              rd_state, take_mem, take_if;
  logic              done_if, done_mem;
  logic [1:0]        cap_idx;

  assign rd_state = (state == IF_RD) ||
                    (state == MEM_RD);
  assign take_mem = (state == IDLE) && bus.mem_req;
  assign take_if  = (state == IDLE) && !bus.mem_req &&
                    bus.if_req && !bus.if_flush;

  // RAM data lags its address by one cycle.
  assign cap_idx = cnt[1:0] - 2'd1;

  mem_ext u_ext (
    .raw     (rbuf),
    .din     (bus.ram_din),
    .idx     (cap_idx),
    .n_bytes (n_bytes),
    .sext    (sext),
    .word    (asm_word),
    .ext     (ext_word)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (take_mem)
          state_n = bus.mem_we ? MEM_WR : MEM_RD;
        else if (take_if)
          state_n = IF_RD;
      end
      IF_RD: begin
        if (bus.if_flush)
          state_n = IDLE;
        else if (cnt == n_bytes)
          state_n = DONE;
      end
      MEM_RD: if (cnt == n_bytes) state_n = DONE;
      MEM_WR: begin
        if (cnt == n_bytes - 3'd1)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      n_bytes     <= '0;
      base        <= '0;
      wdata       <= '0;
      rbuf        <= '0;
      sext        <= 1'b0;
      fetch       <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE || state == DONE)
        cnt <= '0;
      else
        cnt <= cnt + 3'd1;
      if (take_mem) begin
        base    <= bus.mem_addr;
        wdata   <= bus.mem_wdata;
        n_bytes <= len_bytes(bus.mem_len);
        sext    <= bus.mem_sext;
        fetch   <= 1'b0;
      end else if (take_if) begin
        base    <= bus.if_addr;
        n_bytes <= 3'd4;
        sext    <= 1'b0;
        fetch   <= 1'b1;
      end
      if (rd_state && cnt != '0)
        rbuf <= asm_word;
      if (state == IF_RD && state_n == DONE)
        if_data_q <= ext_word;
      if (state == MEM_RD && state_n == DONE)
        mem_rdata_q <= ext_word;
    end
  end

  always_comb begin
    bus.ram_dout = wdata[7:0];
    unique case (cnt[1:0])
      2'd0: bus.ram_dout = wdata[7:0];
      2'd1: bus.ram_dout = wdata[15:8];
      2'd2: bus.ram_dout = wdata[23:16];
      2'd3: bus.ram_dout = wdata[31:24];
    endcase
  end

  assign done_if  = (state == DONE) && fetch;
  assign done_mem = (state == DONE) && !fetch;

  assign bus.ram_addr =
    base + {{(ADDR_W-CNT_W){1'b0}}, cnt};
  assign bus.ram_wr        = (state == MEM_WR);
  assign bus.if_done       = done_if;
  assign bus.mem_done      = done_mem;
  assign bus.if_data       = if_data_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.mem_stall_req = bus.mem_req && !done_mem;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scenario and randomized checks of mem_ctrl against a
// byte-array memory model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram  [0:65535];
  logic [7:0] mref [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a = '0;
  logic [7:0]  poke_d = '0;

  always @(posedge clk) begin
    bus.ram_din <= ram[bus.ram_addr[15:0]];
    if (poke_en)
      ram[poke_a] <= poke_d;
    else if (bus.ram_wr)
      ram[bus.ram_addr[15:0]] <= bus.ram_dout;
  end

  logic [31:0] tr_addr  [0:31];
  logic        tr_wr    [0:31];
  logic [7:0]  tr_dout  [0:31];
  logic        tr_stall [0:31];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a,
                      input logic [7:0] d);
    poke_en = 1'b1;
    poke_a = a;
    poke_d = d;
    mref[a] = d;
    tick();
    poke_en = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(
    input logic [31:0] a, input int n, input bit sx);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++)
      v = v | (32'(mref[16'(a + 32'(k))]) << (8 * k));
    if (sx && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    if (len == 2'd0) return 1;
    if (len == 2'd1) return 2;
    return 4;
  endfunction

  task automatic run(input bit f, input bit we,
                     input logic [31:0] a,
                     input logic [1:0] len, input bit sx,
                     input logic [31:0] wd,
                     output int dcyc,
                     output logic [31:0] data);
    dcyc = -1;
    data = '0;
    for (int i = 0; i < 32; i++) tr_wr[i] = 1'b0;
    if (f) begin
      bus.if_req = 1'b1;
      bus.if_addr = a;
    end else begin
      bus.mem_req = 1'b1;
      bus.mem_we = we;
      bus.mem_addr = a;
      bus.mem_len = len;
      bus.mem_sext = sx;
      bus.mem_wdata = wd;
    end
    for (int c = 1; c < 24; c++) begin
      tick();
      tr_addr[c]  = bus.ram_addr;
      tr_wr[c]    = bus.ram_wr;
      tr_dout[c]  = bus.ram_dout;
      tr_stall[c] = bus.mem_stall_req;
      if (f ? bus.if_done : bus.mem_done) begin
        dcyc = c;
        data = f ? bus.if_data : bus.mem_rdata;
        break;
      end
    end
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.if_done, bus.mem_done, bus.ram_wr} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl: got %b exp 000",
               {bus.if_done, bus.mem_done, bus.ram_wr});
    end
    checks++;
    if ({bus.ram_addr, bus.ram_dout} !== 40'h0) begin
      failures++;
      $display("FAIL reset_ram: addr %h dout %h exp 0",
               bus.ram_addr, bus.ram_dout);
    end
    checks++;
    if ({bus.if_data, bus.mem_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data: if %h mem %h exp 0",
               bus.if_data, bus.mem_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int d;
    logic [31:0] got;
    int bad;
    poke(16'h0100, 8'h13);
    poke(16'h0101, 8'h05);
    poke(16'h0102, 8'h00);
    poke(16'h0103, 8'h00);
    run(1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, d, got);
    bad = 0;
    for (int k = 0; k < 4; k++)
      if (tr_addr[k+1] !== 32'h100 + 32'(k)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fetch_addr: %0d bad addrs exp 0", bad);
    end
    checks++;
    if (d != 6) begin
      failures++;
      $display("FAIL fetch_lat: got %0d exp 6", d);
    end
    checks++;
    if (got !== 32'h0000_0513) begin
      failures++;
      $display("FAIL fetch_data: got %h exp 00000513", got);
    end
  endtask

  task automatic test_priority();
    int mdone, idone;
    logic [31:0] md, iw, a1, a5;
    mdone = -1;
    idone = -1;
    md = '0;
    iw = '0;
    a1 = '0;
    a5 = '0;
    poke(16'h2000, 8'h80);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_addr = 32'h2000;
    bus.mem_len = 2'd0;
    bus.mem_sext = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) a1 = bus.ram_addr;
      if (c == 5) a5 = bus.ram_addr;
      if (bus.mem_done && mdone < 0) begin
        mdone = c;
        md = bus.mem_rdata;
        bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        idone = c;
        iw = bus.if_data;
        bus.if_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0;
    bus.mem_req = 1'b0;
    tick();
    checks++;
    if (a1 !== 32'h2000 || mdone != 3) begin
      failures++;
      $display("FAIL prio_mem: addr %h cyc %0d exp 2000 3",
               a1, mdone);
    end
    checks++;
    if (md !== 32'hFFFF_FF80) begin
      failures++;
      $display("FAIL prio_sext: got %h exp ffffff80", md);
    end
    checks++;
    if (a5 !== 32'h100 || idone != 10) begin
      failures++;
      $display("FAIL prio_if: addr %h cyc %0d exp 100 10",
               a5, idone);
    end
    checks++;
    if (iw !== 32'h0000_0513) begin
      failures++;
      $display("FAIL prio_if_data: got %h exp 00000513", iw);
    end
  endtask

  task automatic test_store_half();
    int d;
    logic [31:0] got;
    run(1'b0, 1'b1, 32'h3000, 2'd1, 1'b0,
        32'h1234_ABCD, d, got);
    checks++;
    if (d != 3) begin
      failures++;
      $display("FAIL sh_lat: got %0d exp 3", d);
    end
    checks++;
    if (tr_wr[1] !== 1'b1 || tr_addr[1] !== 32'h3000 ||
        tr_dout[1] !== 8'hCD) begin
      failures++;
      $display("FAIL sh_b0: wr %b addr %h dout %h exp 1 3000 cd",
               tr_wr[1], tr_addr[1], tr_dout[1]);
    end
    checks++;
    if (tr_wr[2] !== 1'b1 || tr_addr[2] !== 32'h3001 ||
        tr_dout[2] !== 8'hAB) begin
      failures++;
      $display("FAIL sh_b1: wr %b addr %h dout %h exp 1 3001 ab",
               tr_wr[2], tr_addr[2], tr_dout[2]);
    end
    checks++;
    if (tr_wr[3] !== 1'b0 || bus.ram_wr !== 1'b0) begin
      failures++;
      $display("FAIL sh_extra_wr: got %b%b exp 00",
               tr_wr[3], bus.ram_wr);
    end
    checks++;
    if ({tr_stall[1], tr_stall[2], tr_stall[3]} !== 3'b110) begin
      failures++;
      $display("FAIL sh_stall: got %b exp 110",
               {tr_stall[1], tr_stall[2], tr_stall[3]});
    end
  endtask

  task automatic test_flush();
    int idone;
    bit early;
    logic [31:0] a4, iw;
    idone = -1;
    early = 1'b0;
    a4 = '0;
    iw = '0;
    poke(16'h0200, 8'h93);
    poke(16'h0201, 8'h00);
    poke(16'h0202, 8'h10);
    poke(16'h0203, 8'h00);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 2) bus.if_flush = 1'b1;
      if (c == 3) begin
        bus.if_flush = 1'b0;
        bus.if_addr = 32'h200;
      end
      if (c == 4) a4 = bus.ram_addr;
      if (bus.if_done) begin
        idone = c;
        iw = bus.if_data;
        if (c < 9) early = 1'b1;
        break;
      end
    end
    bus.if_req = 1'b0;
    tick();
    checks++;
    if (early || idone != 9) begin
      failures++;
      $display("FAIL flush_done: cyc %0d exp 9", idone);
    end
    checks++;
    if (a4 !== 32'h200 || iw !== 32'h0010_0093) begin
      failures++;
      $display("FAIL flush_refetch: addr %h data %h exp 200 00100093",
               a4, iw);
    end
    idone = -1;
    bus.if_req = 1'b1;
    bus.if_flush = 1'b1;
    bus.if_addr = 32'h100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.if_flush = 1'b0;
      if (bus.if_done) begin
        idone = c;
        break;
      end
    end
    bus.if_req = 1'b0;
    tick();
    checks++;
    if (idone != 7) begin
      failures++;
      $display("FAIL flush_idle_block: cyc %0d exp 7", idone);
    end
  endtask

  task automatic test_reset_mid();
    int wrs, bad;
    wrs = 0;
    bad = 0;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b1;
    bus.mem_addr = 32'h5000;
    bus.mem_len = 2'd2;
    bus.mem_sext = 1'b0;
    bus.mem_wdata = 32'h1122_3344;
    tick();
    if (bus.ram_wr === 1'b1) wrs++;
    tick();
    if (bus.ram_wr === 1'b1) wrs++;
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.ram_wr, bus.mem_done, bus.if_done} !== 3'b000 ||
        {bus.ram_addr, bus.ram_dout} !== 40'h0) begin
      failures++;
      $display("FAIL rstmid_ram: wr %b addr %h dout %h exp 0",
               bus.ram_wr, bus.ram_addr, bus.ram_dout);
    end
    checks++;
    if ({bus.if_data, bus.mem_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL rstmid_data: if %h mem %h exp 0",
               bus.if_data, bus.mem_rdata);
    end
    rst = 1'b0;
    bus.mem_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.ram_wr !== 1'b0 || bus.mem_done !== 1'b0) bad++;
    end
    checks++;
    if (wrs != 2 || bad != 0) begin
      failures++;
      $display("FAIL rstmid_after: wrs %0d bad %0d exp 2 0",
               wrs, bad);
    end
  endtask

  task automatic test_wrap();
    int d, bad;
    logic [31:0] got;
    poke(16'hFFFE, 8'h11);
    poke(16'hFFFF, 8'h22);
    poke(16'h0000, 8'h33);
    poke(16'h0001, 8'h44);
    run(1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 1'b1,
        32'h0, d, got);
    bad = 0;
    if (tr_addr[1] !== 32'hFFFF_FFFE) bad++;
    if (tr_addr[2] !== 32'hFFFF_FFFF) bad++;
    if (tr_addr[3] !== 32'h0000_0000) bad++;
    if (tr_addr[4] !== 32'h0000_0001) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wrap_addr: %0d bad exp 0 (%h %h %h %h)",
               bad, tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]);
    end
    checks++;
    if (d != 6 || got !== 32'h4433_2211) begin
      failures++;
      $display("FAIL wrap_data: cyc %0d data %h exp 6 44332211",
               d, got);
    end
  endtask

  task automatic test_random();
    int kind, n, d, lat, bad;
    logic [31:0] a, wd, got, exp, last_if, last_mem;
    logic [1:0] len;
    bit sx;
    last_if = 32'h0;
    last_mem = 32'h4433_2211;
    for (int i = 0; i < 20; i++)
      poke(16'h4000 + 16'(i), 8'($urandom));
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 2));
      a = 32'h4000 + $urandom_range(0, 15);
      len = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      wd = $urandom;
      n = (kind == 0) ? 4 : nbytes(len);
      exp = (kind == 0) ? ref_load(a, 4, 1'b0)
                        : ref_load(a, n, sx);
      run(kind == 0, kind == 2, a, len, sx, wd, d, got);
      lat = (kind == 2) ? n + 1 : n + 2;
      checks++;
      if (d != lat) begin
        failures++;
        $display("FAIL rnd_lat[%0d]: got %0d exp %0d", it, d, lat);
      end
      if (kind != 2) begin
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL rnd_data[%0d]: got %h exp %h",
                   it, got, exp);
        end
        if (kind == 0) last_if = exp;
        else last_mem = exp;
      end
      bad = 0;
      for (int k = 0; k < n; k++) begin
        if (tr_addr[k+1] !== a + 32'(k)) bad++;
        if (kind == 2 && (tr_wr[k+1] !== 1'b1 ||
            tr_dout[k+1] !== wd[8*k +: 8])) bad++;
      end
      for (int c = 1; c < 24; c++)
        if (tr_wr[c] === 1'b1 && (kind != 2 || c > n)) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rnd_bus[%0d]: %0d bad cycles exp 0",
                 it, bad);
      end
      if (kind == 2)
        for (int k = 0; k < n; k++)
          mref[16'(a + 32'(k))] = wd[8*k +: 8];
      checks++;
      if (kind == 0 && bus.mem_rdata !== last_mem) begin
        failures++;
        $display("FAIL rnd_hold_mem[%0d]: got %h exp %h",
                 it, bus.mem_rdata, last_mem);
      end else if (kind != 0 && bus.if_data !== last_if) begin
        failures++;
        $display("FAIL rnd_hold_if[%0d]: got %h exp %h",
                 it, bus.if_data, last_if);
      end
    end
  endtask

  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.if_flush = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_len = '0;
    bus.mem_sext = 1'b0;
    bus.mem_wdata = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_store_half();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
